// File: rtl/ring_replay_buf.sv
// Replay ring buffer: prefetches from a 1-cycle-latency upstream FIFO, then
// lets the client cycle through the loaded entries for a programmable number of passes.
module ring_replay_buf #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int PASSES = 0
) (
    input  logic                         CLK,
    input  logic                         RESETn,
    input  logic [WIDTH-1:0]             FIFO_RDDATA,
    output logic                         FIFO_RDEN,
    input  logic                         FIFO_RDEMPTY,
    input  logic                         FIFO_DONE,
    input  logic                         FLUSH,
    input  logic                         RDEN,
    output logic [WIDTH-1:0]             RDDATA,
    output logic                         RDVALID,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         FULL,
    output logic                         END,
    output logic                         WRAP,
    output logic [15:0]                  PASS_CNT,
    output logic                         DONE
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_FILL, S_LOADED, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    ridx_q, ridx_d;
    logic             inflight_q;
    logic [WIDTH-1:0] rddata_q, rddata_d;
    logic             rdvalid_q, rdvalid_d;
    logic             wrap_q, wrap_d;
    logic [15:0]      pass_q, pass_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic fifo_rden, accept, last;

    always_comb begin
        last      = (count_q != '0) && (CW'(ridx_q) == count_q - CW'(1));
        // Bound prefetch by occupancy plus the word still in flight so nothing overwrites.
        fifo_rden = RESETn && (state_q == S_FILL) && !FIFO_RDEMPTY &&
                    ((int'(count_q) + int'(inflight_q)) < DEPTH);
        accept    = RDEN && (count_q != '0) && (state_q != S_DONE) && !FLUSH;

        state_d   = state_q;
        count_d   = count_q;
        ridx_d    = ridx_q;
        rddata_d  = rddata_q;
        rdvalid_d = 1'b0;
        wrap_d    = 1'b0;
        pass_d    = pass_q;

        if (accept) begin
            rddata_d  = mem_q[ridx_q];
            rdvalid_d = 1'b1;
            if (last) begin
                ridx_d = '0;
                wrap_d = 1'b1;
                // Wrapping while still filling is not a full pass over the final set.
                if (state_q == S_LOADED && pass_q != 16'hFFFF)
                    pass_d = pass_q + 16'd1;
            end else begin
                ridx_d = ridx_q + 1'b1;
            end
        end

        if (inflight_q)
            count_d = count_q + 1'b1;

        case (state_q)
            S_FILL: begin
                if (count_q == CW'(DEPTH) || (FIFO_DONE && FIFO_RDEMPTY && !inflight_q))
                    state_d = S_LOADED;
            end
            S_LOADED: begin
                if (PASSES > 0 && int'(pass_d) >= PASSES)
                    state_d = S_DONE;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn || FLUSH) begin
            state_q    <= S_FILL;
            count_q    <= '0;
            ridx_q     <= '0;
            inflight_q <= 1'b0;
            rddata_q   <= '0;
            rdvalid_q  <= 1'b0;
            wrap_q     <= 1'b0;
            pass_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ridx_q     <= ridx_d;
            inflight_q <= fifo_rden;
            rddata_q   <= rddata_d;
            rdvalid_q  <= rdvalid_d;
            wrap_q     <= wrap_d;
            pass_q     <= pass_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETn && !FLUSH && inflight_q)
            mem_q[count_q[IW-1:0]] <= FIFO_RDDATA;
    end

    assign FIFO_RDEN = fifo_rden;
    assign RDDATA    = rddata_q;
    assign RDVALID   = rdvalid_q;
    assign COUNT     = count_q;
    assign FULL      = (count_q == CW'(DEPTH));
    assign END       = last;
    assign WRAP      = wrap_q;
    assign PASS_CNT  = pass_q;
    // Unlimited mode never enters S_DONE; it reports exhaustion at the last entry instead.
    assign DONE      = (PASSES > 0) ? (state_q == S_DONE)
                                    : (state_q == S_LOADED && FIFO_DONE && last);
endmodule

// File: tb/tb_ring_replay_buf.sv
// Randomized bench for ring_replay_buf: a PASSES=2 and a PASSES=0 instance, each
// fed by its own upstream FIFO model and checked every cycle against a reference model.
module tb_ring_replay_buf;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

    typedef struct {
        int cnt, rp, pc, ph;
        bit pend;
        logic [D-1:0][W-1:0] mem;
        logic [W-1:0] rdata;
        bit rv, wr;
    } mdl_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESETn = 1'b0, FLUSH = 1'b0, RDEN = 1'b0;
    logic [W-1:0]  fdat[2];
    logic          femp[2], fdn[2], frd[2];
    logic [W-1:0]  rdd[2];
    logic          rdv[2], full[2], endo[2], wrp[2], dn[2];
    logic [CW-1:0] cnt[2];
    logic [15:0]   pcnt[2];

    mdl_t         m[2];
    logic [W-1:0] src[2][256];
    int           popped[2], total[2], nxt_total[2];
    bit           nxt_fd[2], dpend[2];
    logic [W-1:0] dword[2];
    bit           stall_en, stall_tog;
    int           cyc_n = 0;
    int           n_run = 0, n_fail = 0;

    ring_replay_buf #(.WIDTH(W), .DEPTH(D), .PASSES(2)) u_p2 (
        .CLK(CLK), .RESETn(RESETn), .FIFO_RDDATA(fdat[0]), .FIFO_RDEN(frd[0]),
        .FIFO_RDEMPTY(femp[0]), .FIFO_DONE(fdn[0]), .FLUSH(FLUSH), .RDEN(RDEN),
        .RDDATA(rdd[0]), .RDVALID(rdv[0]), .COUNT(cnt[0]), .FULL(full[0]), .END(endo[0]),
        .WRAP(wrp[0]), .PASS_CNT(pcnt[0]), .DONE(dn[0]));

    ring_replay_buf #(.WIDTH(W), .DEPTH(D), .PASSES(0)) u_p0 (
        .CLK(CLK), .RESETn(RESETn), .FIFO_RDDATA(fdat[1]), .FIFO_RDEN(frd[1]),
        .FIFO_RDEMPTY(femp[1]), .FIFO_DONE(fdn[1]), .FLUSH(FLUSH), .RDEN(RDEN),
        .RDDATA(rdd[1]), .RDVALID(rdv[1]), .COUNT(cnt[1]), .FULL(full[1]), .END(endo[1]),
        .WRAP(wrp[1]), .PASS_CNT(pcnt[1]), .DONE(dn[1]));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pas(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit exp_rden(int i);
        return RESETn && m[i].ph == 0 && !femp[i] && (m[i].cnt + int'(m[i].pend) < D);
    endfunction

    function automatic bit exp_end(int i);
        return m[i].cnt > 0 && m[i].rp == m[i].cnt - 1;
    endfunction

    function automatic bit exp_done(int i);
        if (pas(i) > 0) return m[i].ph == 2;
        return m[i].ph == 1 && fdn[i] && exp_end(i);
    endfunction

    // Reference: loaded list with a read cursor, advanced once per clock.
    function automatic void mstep(int i, bit r);
        int oc, oph;
        bit op;
        if (!RESETn || FLUSH) begin
            m[i].cnt = 0; m[i].rp = 0; m[i].pc = 0; m[i].ph = 0; m[i].pend = 0;
            m[i].rdata = '0; m[i].rv = 0; m[i].wr = 0;
            return;
        end
        oc = m[i].cnt; oph = m[i].ph; op = m[i].pend;
        m[i].rv = 0; m[i].wr = 0;
        if (RDEN && oc > 0 && oph != 2) begin
            m[i].rdata = m[i].mem[m[i].rp];
            m[i].rv = 1;
            if (m[i].rp == oc - 1) begin
                m[i].rp = 0;
                m[i].wr = 1;
                if (oph == 1 && m[i].pc < 65535) m[i].pc++;
            end else begin
                m[i].rp++;
            end
        end
        if (op) begin
            m[i].mem[oc] = fdat[i];
            m[i].cnt = oc + 1;
        end
        m[i].pend = r;
        if (oph == 0 && (oc == D || (fdn[i] && femp[i] && !op))) m[i].ph = 1;
        else if (oph == 1 && pas(i) > 0 && m[i].pc >= pas(i)) m[i].ph = 2;
    endfunction

    task automatic cycle(bit rst_n, bit fl, bit rd);
        bit r;
        bit st;
        @(negedge CLK);
        RESETn = rst_n; FLUSH = fl; RDEN = rd;
        for (int i = 0; i < 2; i++) begin
            total[i] = nxt_total[i];
            fdn[i]   = nxt_fd[i];
            st = stall_en && (stall_tog ? (cyc_n % 2 == 1) : ($urandom % 3 == 0));
            femp[i] = (popped[i] >= total[i]) || st;
            fdat[i] = dpend[i] ? dword[i] : W'($urandom);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rden%0d", i),  frd[i],  exp_rden(i));
            chk($sformatf("rddata%0d", i), rdd[i], m[i].rdata);
            chk($sformatf("rdvalid%0d", i), rdv[i], m[i].rv);
            chk($sformatf("count%0d", i), cnt[i],  m[i].cnt);
            chk($sformatf("full%0d", i),  full[i], m[i].cnt == D);
            chk($sformatf("end%0d", i),   endo[i], exp_end(i));
            chk($sformatf("wrap%0d", i),  wrp[i],  m[i].wr);
            chk($sformatf("pass%0d", i),  pcnt[i], m[i].pc);
            chk($sformatf("done%0d", i),  dn[i],   exp_done(i));
        end
        for (int i = 0; i < 2; i++) begin
            r = exp_rden(i);
            dpend[i] = r;
            if (r) begin
                dword[i] = src[i][popped[i]];
                popped[i]++;
            end
            mstep(i, r);
        end
        cyc_n++;
    endtask

    initial begin
        logic [W-1:0] seq0 [4];
        logic [W-1:0] seq1 [2];
        bit rst, fl;
        seq0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        seq1 = '{8'hA1, 8'hA2};
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) src[i][k] = W'($urandom);
            popped[i] = 0; total[i] = 0; nxt_total[i] = 0; nxt_fd[i] = 0;
            dpend[i] = 0; femp[i] = 1; fdn[i] = 0; fdat[i] = '0;
            m[i].cnt = 0; m[i].rp = 0; m[i].pc = 0; m[i].ph = 0; m[i].pend = 0;
            m[i].mem = '0; m[i].rdata = '0; m[i].rv = 0; m[i].wr = 0;
        end
        for (int k = 0; k < 4; k++) src[0][k] = seq0[k];
        for (int k = 0; k < 2; k++) src[1][k] = seq1[k];
        stall_en = 0; stall_tog = 0;

        repeat (2) @(posedge CLK);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // Full fill 11..44 (PASSES=2) and partial fill A1,A2 (PASSES=0).
        nxt_total[0] = 4; nxt_total[1] = 2; nxt_fd[0] = 1; nxt_fd[1] = 1;
        repeat (8) cycle(1, 0, 0);
        repeat (8) cycle(1, 0, 1);
        cycle(1, 0, 1);
        chk("dir_pass_cnt", pcnt[0], 2);
        chk("dir_done", dn[0], 1);
        chk("dir_last_data", rdd[0], 8'h44);
        chk("dir_partial_cnt", cnt[1], 2);
        cycle(1, 0, 0);
        chk("dir_9th_rdvalid", rdv[0], 0);

        // Flush with COUNT=3 and a word in flight, then refill from index 0.
        for (int i = 0; i < 2; i++) nxt_total[i] = popped[i] + 10;
        cycle(1, 1, 0);
        repeat (4) cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        chk("flush_count", cnt[0], 0);
        chk("flush_rdvalid", rdv[0], 0);
        repeat (8) cycle(1, 0, 1);

        // Randomized epochs: stalls, flushes, resets, random client reads.
        stall_en = 1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 151) == 0;
            fl  = ($urandom % 29) == 0;
            if (rst || fl) begin
                stall_tog = $urandom % 2;
                for (int i = 0; i < 2; i++) begin
                    nxt_total[i] = popped[i] + int'($urandom_range(0, 7));
                    if (nxt_total[i] > 256) nxt_total[i] = 256;
                    nxt_fd[i] = ($urandom % 4) != 0;
                end
            end
            cycle(!rst, fl, ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
